// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers, default geometry and small types for the fifo_param slice.
package fifo_pkg;

   localparam int FIFO_DEFAULT_W        = 64;
   localparam int FIFO_DEFAULT_DEPTH    = 8;
   localparam int FIFO_DEFAULT_AFULL_TH = 6;

   // Pointer width: indexes 0..DEPTH-1, never narrower than one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Level width: must represent 0..DEPTH inclusive.
   function automatic int level_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Accepted operations this cycle, encoded as {wr_acc, rd_acc}.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } fifo_op_e;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } sticky_t;

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_W storage array with one synchronous write port
// and one asynchronous read port.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int DATA_W = FIFO_DEFAULT_W,
   parameter int DEPTH  = FIFO_DEFAULT_DEPTH,
   parameter int PTR_W  = ptr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [PTR_W-1:0]  wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [PTR_W-1:0]  rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: storage has no reset so it maps onto plain RAM/register-file
   // cells; occupancy logic guarantees stale words are never presented.
   // NOTE: sequential state uses non-blocking (<=) so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with fill level, sticky overflow/underflow
// flags and synchronous flush. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_W   = FIFO_DEFAULT_W,
   parameter int DEPTH    = FIFO_DEFAULT_DEPTH,
   parameter int AFULL_TH = FIFO_DEFAULT_AFULL_TH
) (
   input  logic                          clock_i,
   input  logic                          rst_n_i,
   input  logic                          flush_i,
   input  logic [DATA_W-1:0]             data_in_i,
   input  logic                          data_in_v_i,
   output logic                          data_in_bkp_o,
   input  logic                          data_out_req_i,
   output logic [DATA_W-1:0]             data_out_o,
   output logic                          data_out_v_o,
   output logic [level_width(DEPTH)-1:0] level_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic                          overflow_o,
   output logic                          underflow_o
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int LVL_W = level_width(DEPTH);

   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] AFULL_LVL = LVL_W'(AFULL_TH);

   logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
   logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
   logic [LVL_W-1:0]  level, level_nxt;
   sticky_t           sticky, sticky_nxt;
   logic              rd_acc;
   logic              wr_acc;
   fifo_op_e          op;
   logic [DATA_W-1:0] head;

   // DEPTH need not be a power of two, so wrap on an explicit compare.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
   endfunction

   // Status decoded straight from the registered level.
   assign empty_o       = (level == '0);
   assign full_o        = (level == FULL_LVL);
   assign data_in_bkp_o = (level >= AFULL_LVL);
   assign level_o       = level;
   assign overflow_o    = sticky.overflow;
   assign underflow_o   = sticky.underflow;

   // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
   assign rd_acc = data_out_req_i & ~empty_o;
   assign wr_acc = data_in_v_i & (~full_o | rd_acc);
   assign op     = fifo_op_e'({wr_acc, rd_acc});

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the if/case can leave a value unassigned and infer a latch.
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      level_nxt  = level;
      sticky_nxt = sticky;

      if (flush_i) begin
         // Flush discards any same-cycle read or write without touching the flags.
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
         level_nxt  = '0;
      end else begin
         if (wr_acc) wr_ptr_nxt = ptr_inc(wr_ptr);
         if (rd_acc) rd_ptr_nxt = ptr_inc(rd_ptr);

         case (op)
            OP_PUSH: level_nxt = level + LVL_W'(1);
            OP_POP:  level_nxt = level - LVL_W'(1);
            default: level_nxt = level;
         endcase

         sticky_nxt.overflow  = sticky.overflow  | (data_in_v_i & ~wr_acc);
         sticky_nxt.underflow = sticky.underflow | (data_out_req_i & empty_o);
      end
   end

   always_ff @(posedge clock_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         sticky <= '0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         rd_ptr <= rd_ptr_nxt;
         level  <= level_nxt;
         sticky <= sticky_nxt;
      end
   end

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_ram (
      .clk     (clock_i),
      .wr_en   (wr_acc & ~flush_i),
      .wr_addr (wr_ptr),
      .wr_data (data_in_i),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

`ifdef FIFO_FWFT_EN
   // Head entry is presented combinationally; a request simply pops it.
   assign data_out_o   = empty_o ? '0 : head;
   assign data_out_v_o = ~empty_o;
`else
   always_ff @(posedge clock_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_out_o   <= '0;
         data_out_v_o <= 1'b0;
      end else if (flush_i) begin
         data_out_v_o <= 1'b0;
      end else begin
         data_out_v_o <= rd_acc;
         if (rd_acc) begin
            data_out_o <= head;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed scenarios plus randomized traffic for fifo_param, checked
// every cycle against a queue-based reference model (standard and FIFO_FWFT_EN builds).
module tb_fifo_param;

   localparam int DATA_W   = 64;
   localparam int DEPTH    = 8;
   localparam int AFULL_TH = 6;
   localparam int LVL_W    = $clog2(DEPTH + 1);

   logic              clock_i;
   logic              rst_n_i;
   logic              flush_i;
   logic [DATA_W-1:0] data_in_i;
   logic              data_in_v_i;
   logic              data_in_bkp_o;
   logic              data_out_req_i;
   logic [DATA_W-1:0] data_out_o;
   logic              data_out_v_o;
   logic [LVL_W-1:0]  level_o;
   logic              full_o;
   logic              empty_o;
   logic              overflow_o;
   logic              underflow_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state.
   logic [63:0] q[$];
   bit          m_of;
   bit          m_uf;
   bit          m_v;
   logic [63:0] m_dout;

   fifo_param #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AFULL_TH (AFULL_TH)
   ) dut (
      .clock_i        (clock_i),
      .rst_n_i        (rst_n_i),
      .flush_i        (flush_i),
      .data_in_i      (data_in_i),
      .data_in_v_i    (data_in_v_i),
      .data_in_bkp_o  (data_in_bkp_o),
      .data_out_req_i (data_out_req_i),
      .data_out_o     (data_out_o),
      .data_out_v_o   (data_out_v_o),
      .level_o        (level_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o)
   );

   initial begin
      clock_i = 1'b0;
      forever #5 clock_i = ~clock_i;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached before end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_of   = 1'b0;
      m_uf   = 1'b0;
      m_v    = 1'b0;
      m_dout = '0;
   endtask

   // One clock edge of the reference behaviour.
   task automatic model_clock(input logic v, input logic [63:0] d, input logic req, input logic fl);
      bit rd;
      bit wr;
      if (fl) begin
         q.delete();
         m_v = 1'b0;
         return;
      end
      rd = req && (q.size() > 0);
      wr = v && ((q.size() < DEPTH) || rd);
      if (req && !rd) m_uf = 1'b1;
      if (v && !wr)   m_of = 1'b1;
      m_v = 1'b0;
      if (rd) begin
         m_dout = q.pop_front();
         m_v    = 1'b1;
      end
      if (wr) q.push_back(d);
   endtask

   task automatic check_outputs();
      check("level", 64'(level_o), 64'(q.size()));
      check("empty", 64'(empty_o), 64'(q.size() == 0));
      check("full", 64'(full_o), 64'(q.size() == DEPTH));
      check("bkp", 64'(data_in_bkp_o), 64'(q.size() >= AFULL_TH));
      check("overflow", 64'(overflow_o), 64'(m_of));
      check("underflow", 64'(underflow_o), 64'(m_uf));
`ifdef FIFO_FWFT_EN
      check("dout_v", 64'(data_out_v_o), 64'(q.size() != 0));
      if (q.size() != 0) check("dout", data_out_o, q[0]);
`else
      check("dout_v", 64'(data_out_v_o), 64'(m_v));
      check("dout", data_out_o, m_dout);
`endif
   endtask

   // Called at a falling edge: check, drive, advance one rising edge, return at next falling edge.
   task automatic step(input logic v, input logic [63:0] d, input logic req, input logic fl);
      check_outputs();
      data_in_v_i    = v;
      data_in_i      = d;
      data_out_req_i = req;
      flush_i        = fl;
      @(posedge clock_i);
      model_clock(v, d, req, fl);
      @(negedge clock_i);
   endtask

   task automatic idle_inputs();
      data_in_v_i    = 1'b0;
      data_in_i      = '0;
      data_out_req_i = 1'b0;
      flush_i        = 1'b0;
   endtask

   task automatic full_reset();
      idle_inputs();
      rst_n_i = 1'b0;
      model_reset();
      repeat (2) @(negedge clock_i);
      rst_n_i = 1'b1;
   endtask

   initial begin
      logic [63:0] rnd;
      idle_inputs();
      model_reset();
      rst_n_i = 1'b0;
      repeat (2) @(negedge clock_i);
      check_outputs();
      rst_n_i = 1'b1;

      // 1: reset asserted between edges after three writes.
      for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      idle_inputs();
      @(posedge clock_i);
      #2 rst_n_i = 1'b0;
      #1;
      model_reset();
      check("rst_level", 64'(level_o), 64'd0);
      check("rst_dout", data_out_o, 64'd0);
      check_outputs();
      @(negedge clock_i);
      @(negedge clock_i);
      rst_n_i = 1'b1;

      // 2: ordering.
      step(1'b1, 64'hFFFF, 1'b0, 1'b0);
      step(1'b1, 64'hBBBB, 1'b0, 1'b0);
      step(1'b1, 64'hCCCC, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);

      // 3: fill past capacity.
      for (int i = 0; i < AFULL_TH; i++) step(1'b1, 64'h3000 + 64'(i), 1'b0, 1'b0);
      check("t3_bkp_at_th", 64'(data_in_bkp_o), 64'd1);
      for (int i = AFULL_TH; i < DEPTH + 1; i++) step(1'b1, 64'h3000 + 64'(i), 1'b0, 1'b0);
      check("t3_level_full", 64'(level_o), 64'(DEPTH));
      check("t3_full", 64'(full_o), 64'd1);
      check("t3_overflow", 64'(overflow_o), 64'd1);

      // 4: full with simultaneous read/write across the pointer wrap.
      full_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, 64'h4000 + 64'(i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 64'h4100 + 64'(i), 1'b1, 1'b0);
      check("t4_level", 64'(level_o), 64'(DEPTH));
      check("t4_no_overflow", 64'(overflow_o), 64'd0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

      // 5: empty behaviour.
      step(1'b0, '0, 1'b1, 1'b0);
      check("t5_underflow", 64'(underflow_o), 64'd1);
      step(1'b1, 64'h5555, 1'b1, 1'b0);
      check("t5_level", 64'(level_o), 64'd1);

      // 6: flush at level 5 with concurrent write and request.
      for (int i = 0; i < 4; i++) step(1'b1, 64'h6000 + 64'(i), 1'b0, 1'b0);
      check("t6_level5", 64'(level_o), 64'd5);
      step(1'b1, 64'h6666, 1'b1, 1'b1);
      check("t6_level0", 64'(level_o), 64'd0);
      check("t6_empty", 64'(empty_o), 64'd1);
      check("t6_dout_v", 64'(data_out_v_o), 64'd0);
      check("t6_underflow_kept", 64'(underflow_o), 64'd1);

      // Randomized traffic in write-heavy, read-heavy and balanced phases.
      full_reset();
      for (int i = 0; i < 600; i++) begin
         int wr_pct;
         int rd_pct;
         case ((i / 100) % 3)
            0:       begin wr_pct = 80; rd_pct = 30; end
            1:       begin wr_pct = 30; rd_pct = 80; end
            default: begin wr_pct = 55; rd_pct = 55; end
         endcase
         rnd = {$urandom, $urandom};
         step(($urandom_range(99) < wr_pct), rnd, ($urandom_range(99) < rd_pct),
              ($urandom_range(59) == 0));
      end
      check_outputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
